// File: rtl/gpio_cfg_pkg.sv
// Shared constants, field map and state encoding for the per-pad GPIO
// configuration loader.
package gpio_cfg_pkg;

    localparam int GPIO_BITS = 13;
    localparam int CNT_W     = 5;
    localparam logic [CNT_W-1:0] CNT_MAX = 5'd31;

    // Bit positions of the decoded fields inside the configuration word
    localparam int MGMT_ENA    = 0;
    localparam int OUTENB      = 1;
    localparam int HOLDOVER    = 2;
    localparam int INP_DIS     = 3;
    localparam int IB_MODE_SEL = 4;
    localparam int ANALOG_EN   = 5;
    localparam int ANALOG_SEL  = 6;
    localparam int ANALOG_POL  = 7;
    localparam int SLOW_SEL    = 8;
    localparam int VTRIP_SEL   = 9;
    localparam int DM_LSB      = 10;
    localparam int DM_MSB      = 12;

    localparam logic [2:0] DM_ANALOG       = 3'b000;
    localparam logic [2:0] DM_INPUT_NOPULL = 3'b001;
    localparam logic [2:0] DM_INPUT_PULLUP = 3'b010;
    localparam logic [2:0] DM_STRONG       = 3'b110;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // Counter increment that sticks at the top value instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        if (value == CNT_MAX) begin
            return value;
        end else begin
            return value + 5'd1;
        end
    endfunction

endpackage

// File: rtl/gpio_cfg_shift_reg.sv
// Serial shift register with a saturating shift counter; both reload from the
// static default word on reset or on request.
module gpio_cfg_shift_reg #(
    parameter int WIDTH = 13
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [WIDTH-1:0]               defaults,
    input  logic                           load_defaults,
    input  logic                           clr_cnt,
    input  logic                           shift_en,
    input  logic                           data_in,
    output logic [WIDTH-1:0]               shift_q,
    output logic [gpio_cfg_pkg::CNT_W-1:0] bit_cnt
);
    import gpio_cfg_pkg::*;

    logic [WIDTH-1:0] shift_r;
    logic [CNT_W-1:0] cnt_r;

    // Shift path and bit counter; a pending commit clears the count and drops any shift
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r <= defaults;
            cnt_r   <= 5'd0;
        end else if (load_defaults) begin
            shift_r <= defaults;
            cnt_r   <= 5'd0;
        end else if (clr_cnt) begin
            cnt_r   <= 5'd0;
        end else if (shift_en) begin
            shift_r <= {shift_r[WIDTH-2:0], data_in};
            cnt_r   <= sat_inc(cnt_r);
        end
    end

    assign shift_q = shift_r;
    assign bit_cnt = cnt_r;

endmodule

// File: rtl/gpio_cfg_serial_loader.sv
// Per-pad configuration stage: defaults on reset, serial rewrite with an
// explicit commit strobe, and decode of the committed word to pad controls.
module gpio_cfg_serial_loader #(
    parameter int GPIO_BITS    = gpio_cfg_pkg::GPIO_BITS,
    parameter int STRICT_COUNT = 0
) (
    input  logic                 serial_clock,
    input  logic                 resetn,
    input  logic [GPIO_BITS-1:0] gpio_defaults,
    input  logic                 reload_defaults,
    input  logic                 serial_shift_en,
    input  logic                 serial_data_in,
    input  logic                 serial_load,
    output logic                 serial_data_out,
    output logic [GPIO_BITS-1:0] gpio_cfg,
    output logic                 cfg_update,
    output logic                 load_err,
    output logic                 mgmt_ena,
    output logic                 outenb,
    output logic                 holdover,
    output logic                 inp_dis,
    output logic                 ib_mode_sel,
    output logic                 analog_en,
    output logic                 analog_sel,
    output logic                 analog_pol,
    output logic                 slow_sel,
    output logic                 vtrip_sel,
    output logic [2:0]           dm
);
    import gpio_cfg_pkg::*;

    localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(GPIO_BITS);

    state_t                 state_r;
    logic [GPIO_BITS-1:0]   gpio_cfg_r;
    logic                   cfg_update_r;
    logic                   load_err_r;
    logic [GPIO_BITS-1:0]   shift_word_s;
    logic [CNT_W-1:0]       bit_cnt_s;
    logic                   shift_go_s;
    logic                   in_commit_s;
    logic                   commit_ok_s;

    // Shifts arriving while a commit is in flight are dropped, not queued
    assign in_commit_s = (state_r == COMMIT);
    assign shift_go_s  = serial_shift_en && !in_commit_s;

    gpio_cfg_shift_reg #(
        .WIDTH (GPIO_BITS)
    ) u_shift (
        .clk           (serial_clock),
        .rst_n         (resetn),
        .defaults      (gpio_defaults),
        .load_defaults (reload_defaults),
        .clr_cnt       (in_commit_s),
        .shift_en      (shift_go_s),
        .data_in       (serial_data_in),
        .shift_q       (shift_word_s),
        .bit_cnt       (bit_cnt_s)
    );

    // Strict mode wants exactly one word; chained mode accepts any longer stream
    always_comb begin
        commit_ok_s = 1'b0;
        if (STRICT_COUNT != 0) begin
            commit_ok_s = (bit_cnt_s == CNT_TARGET);
        end else begin
            commit_ok_s = (bit_cnt_s >= CNT_TARGET);
        end
    end

    // Control FSM with the committed word, update pulse and sticky error
    always_ff @(posedge serial_clock or negedge resetn) begin
        if (!resetn) begin
            state_r      <= IDLE;
            gpio_cfg_r   <= gpio_defaults;
            cfg_update_r <= 1'b0;
            load_err_r   <= 1'b0;
        end else if (reload_defaults) begin
            state_r      <= IDLE;
            gpio_cfg_r   <= gpio_defaults;
            cfg_update_r <= 1'b1;
            load_err_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    cfg_update_r <= 1'b0;
                    if (serial_load) begin
                        state_r <= COMMIT;
                    end else if (serial_shift_en) begin
                        state_r <= SHIFT;
                    end
                end
                SHIFT: begin
                    cfg_update_r <= 1'b0;
                    if (serial_load) begin
                        state_r <= COMMIT;
                    end
                end
                COMMIT: begin
                    state_r <= IDLE;
                    if (commit_ok_s) begin
                        gpio_cfg_r   <= shift_word_s;
                        cfg_update_r <= 1'b1;
                    end else begin
                        load_err_r   <= 1'b1;
                        cfg_update_r <= 1'b0;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    cfg_update_r <= 1'b0;
                end
            endcase
        end
    end

    assign serial_data_out = shift_word_s[GPIO_BITS-1];
    assign gpio_cfg        = gpio_cfg_r;
    assign cfg_update      = cfg_update_r;
    assign load_err        = load_err_r;

    assign mgmt_ena    = gpio_cfg_r[MGMT_ENA];
    assign outenb      = gpio_cfg_r[OUTENB];
    assign holdover    = gpio_cfg_r[HOLDOVER];
    assign inp_dis     = gpio_cfg_r[INP_DIS];
    assign ib_mode_sel = gpio_cfg_r[IB_MODE_SEL];
    assign analog_en   = gpio_cfg_r[ANALOG_EN];
    assign analog_sel  = gpio_cfg_r[ANALOG_SEL];
    assign analog_pol  = gpio_cfg_r[ANALOG_POL];
    assign slow_sel    = gpio_cfg_r[SLOW_SEL];
    assign vtrip_sel   = gpio_cfg_r[VTRIP_SEL];
    assign dm          = gpio_cfg_r[DM_MSB:DM_LSB];

endmodule

// File: tb/tb_gpio_cfg_serial_loader.sv
// Bench: one strict stand-alone instance (index 0) and a three-stage
// non-strict chain (indices 1..3), checked every cycle against a word model.
module tb_gpio_cfg_serial_loader;

    localparam logic [12:0] DEFS [4] = '{13'h0403, 13'h0C05, 13'h1001, 13'h1FFE};

    logic clk = 1'b0;
    initial forever #5 clk = ~clk;

    logic resetn;
    logic s_shift, s_load, s_reload, s_sdi;
    logic c_shift, c_load, c_reload, c_sdi;

    logic [12:0] d_cfg [4];
    logic [12:0] d_dec [4];
    logic        d_upd [4];
    logic        d_err [4];
    logic        d_sdo [4];

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_dut
            logic sdi_w, sh_w, ld_w, rl_w;
            logic f0, f1, f2, f3, f4, f5, f6, f7, f8, f9;
            logic [2:0] dm_w;
            if (g == 0) begin : g_in
                assign sdi_w = s_sdi;
            end else if (g == 1) begin : g_in
                assign sdi_w = c_sdi;
            end else begin : g_in
                assign sdi_w = d_sdo[g-1];
            end
            assign sh_w = (g == 0) ? s_shift  : c_shift;
            assign ld_w = (g == 0) ? s_load   : c_load;
            assign rl_w = (g == 0) ? s_reload : c_reload;

            gpio_cfg_serial_loader #(
                .GPIO_BITS    (13),
                .STRICT_COUNT ((g == 0) ? 1 : 0)
            ) u_dut (
                .serial_clock    (clk),
                .resetn          (resetn),
                .gpio_defaults   (DEFS[g]),
                .reload_defaults (rl_w),
                .serial_shift_en (sh_w),
                .serial_data_in  (sdi_w),
                .serial_load     (ld_w),
                .serial_data_out (d_sdo[g]),
                .gpio_cfg        (d_cfg[g]),
                .cfg_update      (d_upd[g]),
                .load_err        (d_err[g]),
                .mgmt_ena        (f0),
                .outenb          (f1),
                .holdover        (f2),
                .inp_dis         (f3),
                .ib_mode_sel     (f4),
                .analog_en       (f5),
                .analog_sel      (f6),
                .analog_pol      (f7),
                .slow_sel        (f8),
                .vtrip_sel       (f9),
                .dm              (dm_w)
            );
            assign d_dec[g] = {dm_w, f9, f8, f7, f6, f5, f4, f3, f2, f1, f0};
        end
    endgenerate

    // Model: shifted word, shift count, pending commit, and visible outputs
    logic [12:0] m_w   [4];
    logic [12:0] m_cfg [4];
    int          m_c   [4];
    bit          m_pend[4];
    bit          m_upd [4];
    bit          m_err [4];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_w[i]    = DEFS[i];
            m_cfg[i]  = DEFS[i];
            m_c[i]    = 0;
            m_pend[i] = 1'b0;
            m_upd[i]  = 1'b0;
            m_err[i]  = 1'b0;
        end
    endtask

    // Highest index first so each stage sees its upstream neighbour's old MSB
    task automatic model_tick();
        if (!resetn) begin
            model_reset();
        end else begin
            for (int i = 3; i >= 0; i--) begin
                bit sh, ld, rl, din;
                if (i == 0) begin
                    sh = s_shift; ld = s_load; rl = s_reload; din = s_sdi;
                end else begin
                    sh = c_shift; ld = c_load; rl = c_reload;
                    if (i == 1) din = c_sdi;
                    else        din = m_w[i-1][12];
                end
                if (rl) begin
                    m_w[i] = DEFS[i]; m_cfg[i] = DEFS[i]; m_c[i] = 0;
                    m_err[i] = 1'b0; m_pend[i] = 1'b0; m_upd[i] = 1'b1;
                end else if (m_pend[i]) begin
                    if ((i == 0) ? (m_c[i] == 13) : (m_c[i] >= 13)) begin
                        m_cfg[i] = m_w[i];
                        m_upd[i] = 1'b1;
                    end else begin
                        m_err[i] = 1'b1;
                        m_upd[i] = 1'b0;
                    end
                    m_c[i] = 0;
                    m_pend[i] = 1'b0;
                end else begin
                    m_upd[i] = 1'b0;
                    if (sh) begin
                        m_w[i] = {m_w[i][11:0], din};
                        if (m_c[i] < 31) m_c[i] = m_c[i] + 1;
                    end
                    if (ld) m_pend[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("cfg%0d", i), d_cfg[i], m_cfg[i]);
            chk($sformatf("dec%0d", i), d_dec[i], m_cfg[i]);
            chk($sformatf("upd%0d", i), d_upd[i], m_upd[i]);
            chk($sformatf("err%0d", i), d_err[i], m_err[i]);
            chk($sformatf("sdo%0d", i), d_sdo[i], m_w[i][12]);
        end
    endtask

    task automatic step();
        model_tick();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic s_shift_bits(input logic [12:0] w, input int n);
        for (int k = n - 1; k >= 0; k--) begin
            s_shift = 1'b1;
            s_sdi   = w[k];
            step();
        end
        s_shift = 1'b0;
    endtask

    task automatic c_shift_bits(input logic [38:0] w);
        for (int k = 38; k >= 0; k--) begin
            c_shift = 1'b1;
            c_sdi   = w[k];
            step();
        end
        c_shift = 1'b0;
    endtask

    task automatic s_load_pulse();
        s_load = 1'b1;
        step();
        s_load = 1'b0;
    endtask

    initial begin
        resetn = 1'b0;
        s_shift = 1'b0; s_load = 1'b0; s_reload = 1'b0; s_sdi = 1'b0;
        c_shift = 1'b0; c_load = 1'b0; c_reload = 1'b0; c_sdi = 1'b0;
        model_reset();

        // Reset state
        repeat (5) step();
        chk("rst_cfg", d_cfg[0], 13'h0403);
        chk("rst_mgmt_ena", d_dec[0][0], 1'b1);
        chk("rst_outenb", d_dec[0][1], 1'b1);
        chk("rst_dm", d_dec[0][12:10], 3'b001);
        chk("rst_sdo", d_sdo[0], 1'b0);
        chk("rst_load_err", d_err[0], 1'b0);
        chk("rst_cfg_update", d_upd[0], 1'b0);
        resetn = 1'b1;
        repeat (2) step();

        // Exact 13-bit commit on the strict instance
        s_shift_bits(13'h1808, 13);
        s_load_pulse();
        chk("commit_not_early", d_cfg[0], 13'h0403);
        step();
        chk("commit_cfg", d_cfg[0], 13'h1808);
        chk("commit_dm", d_dec[0][12:10], 3'b110);
        chk("commit_upd", d_upd[0], 1'b1);
        step();
        chk("commit_upd_drop", d_upd[0], 1'b0);

        // Short word rejected in strict mode, error sticky, cleared by reload
        s_shift_bits(13'h0ABC, 12);
        s_load_pulse();
        step();
        chk("short_cfg_kept", d_cfg[0], 13'h1808);
        chk("short_err", d_err[0], 1'b1);
        repeat (3) step();
        chk("short_err_sticky", d_err[0], 1'b1);
        s_reload = 1'b1;
        step();
        s_reload = 1'b0;
        chk("reload_cfg", d_cfg[0], 13'h0403);
        chk("reload_err", d_err[0], 1'b0);
        chk("reload_upd", d_upd[0], 1'b1);
        step();

        // Three-stage chain with 39 bits and a common load
        c_shift_bits({13'h1808, 13'h0A5A, 13'h1F0F});
        c_load = 1'b1;
        step();
        c_load = 1'b0;
        step();
        chk("chain_last", d_cfg[3], 13'h1808);
        chk("chain_mid", d_cfg[2], 13'h0A5A);
        chk("chain_first", d_cfg[1], 13'h1F0F);
        chk("chain_err", {d_err[1], d_err[2], d_err[3]}, 3'b000);
        chk("chain_upd", {d_upd[1], d_upd[2], d_upd[3]}, 3'b111);
        step();

        // Shift and load together on bit 13, then a shift during commit is dropped
        s_shift_bits(13'h091A, 12);
        s_shift = 1'b1; s_sdi = 1'b0; s_load = 1'b1;
        step();
        s_load = 1'b0; s_sdi = 1'b1;
        step();
        s_shift = 1'b0;
        chk("same_cycle_cfg", d_cfg[0], 13'h1234);
        chk("same_cycle_upd", d_upd[0], 1'b1);
        chk("drop_sdo", d_sdo[0], 1'b1);
        s_load_pulse();
        step();
        chk("drop_cnt_zero_err", d_err[0], 1'b1);

        // Asynchronous reset in the middle of a shift
        s_reload = 1'b1;
        step();
        s_reload = 1'b0;
        s_shift_bits(13'h007F, 7);
        resetn = 1'b0;
        model_reset();
        #2;
        compare_all();
        chk("areset_cfg", d_cfg[0], 13'h0403);
        chk("areset_sdo", d_sdo[0], 1'b0);
        repeat (2) step();
        resetn = 1'b1;
        step();
        s_load_pulse();
        step();
        chk("areset_empty_load_err", d_err[0], 1'b1);
        chk("areset_empty_load_cfg", d_cfg[0], 13'h0403);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
